shift_reg_universal: RTL
========================

// Module: shift_reg_universal
// PURPOSE
//  Parametrised universal shift register: the multi-bit, multi-mode successor to the single-bit D flip-flop.
//  Per-cycle hold / shift-right / shift-left / parallel-load, plus a burst engine that performs N shifts unattended.
//  Used as the serializer/deserializer and general storage register in the sequential-circuit library.
// PARAMETERS
//  WIDTH      8   register width in bits, >= 2
//  RESET_VAL  0   WIDTH-bit value loaded into q on reset and on clr
//  CNT_W      $clog2(WIDTH+1)   width of len/counter; derived, do not override
// PORTS
//  clk     in   1      rising-edge clock
//  rst     in   1      asynchronous active-high reset
//  clr     in   1      synchronous clear; highest priority after rst
//  mode    in   2      00 hold, 01 shift right, 10 shift left, 11 parallel load
//  d       in   WIDTH  parallel load data
//  sin_r   in   1      serial in for right shift; enters q[WIDTH-1]
//  sin_l   in   1      serial in for left shift; enters q[0]
//  start   in   1      begin burst shift in direction given by mode (01/10)
//  len     in   CNT_W  number of burst shifts
//  rot     in   1      rotate select (present only with SHREG_ROTATE_EN)
//  q       out  WIDTH  register contents
//  q_n     out  WIDTH  ~q, combinational
//  sout_r  out  1      q[0] (bit leaving on right shift)
//  sout_l  out  1      q[WIDTH-1] (bit leaving on left shift)
//  busy    out  1      high while in SHIFT state
//  done    out  1      one-cycle pulse at burst completion
// BEHAVIOUR
//  - rst=1 (async, any time): q=RESET_VAL, state IDLE, counter 0, busy=0, done=0; q_n=~RESET_VAL.
//  - Priority at each rising edge: clr > burst (SHIFT) > start > mode.
//  - clr=1: q=RESET_VAL, state IDLE, busy=0, done=0; aborts a burst with no done pulse.
//  - IDLE, start=0: mode acts that edge. Right: q<={sin_r,q[WIDTH-1:1]}. Left: q<={q[WIDTH-2:0],sin_l}.
//    Load: q<=d. Hold: q unchanged.
//  - IDLE, start=1, mode 01/10: latch direction and cnt=min(len,WIDTH); q not modified this edge.
//    cnt>0 -> SHIFT; cnt==0 -> stay IDLE, done=1 next cycle.
//  - IDLE, start=1, mode 00/11: start ignored; mode acts normally; no done.
//  - SHIFT: each edge shifts q in latched direction using live sin_r/sin_l, cnt<=cnt-1; mode/start/len ignored.
//    At the edge shifting with cnt==1: -> IDLE, done=1 for the following cycle.
//  - Latency: start sampled at edge k, shifts at edges k+1..k+len, busy high cycles k+1..k+len, done high
//    the cycle after edge k+len; a new start is accepted in that done cycle (back-to-back bursts).
//  - done is registered, high for exactly one cycle; busy = (state==SHIFT), registered.
//  - len > WIDTH saturates to WIDTH; counter never wraps.
//  - Outputs q, sout_r, sout_l valid from registers; no combinational path from inputs to q.
// CONFIGURATION
//  SHREG_ROTATE_EN defined: port rot exists; rot=1 replaces serial input with the bit leaving the
//   register (right: sin=q[0]; left: sin=q[WIDTH-1]), in both IDLE modes and bursts (sampled each edge).
//  SHREG_ROTATE_EN undefined: no rot port; serial input always sin_r/sin_l.
// TESTING (WIDTH=8, RESET_VAL=8'h00)
//  1 rst=1 mid-run with q=8'hA5 -> q=8'h00, q_n=8'hFF, busy=0, done=0 immediately (before next edge).
//  2 mode=11 d=8'h3C, then mode=01 sin_r=1 x2 -> q=8'h3C, 8'h9E, 8'hCF; mode=00 holds 8'hCF.
//  3 q=8'h81, start mode=10 len=3 sin_l=0 -> busy 3 cycles, q=8'h02,8'h04,8'h08, done 1 cycle after last.
//  4 start len=0 -> no shift, busy=0, done pulse next cycle; start len=12 -> exactly 8 shifts.
//  5 burst len=5 with clr at 2nd shift -> q=8'h00, busy=0, no done; rst mid-burst likewise.
//  6 SHREG_ROTATE_EN: q=8'h81 rot=1 mode=01 -> 8'hC0, 8'h60; without macro, sin_r=0 -> 8'h40.

Source files
------------

// File: rtl/shift_reg_universal.sv
// ---------------------------------------------------------------------------
// shift_reg_universal
//
// Parametrised universal shift register. Each cycle it can hold, shift
// right, shift left or parallel-load. A burst engine can also run a given
// number of shifts in one direction without further input.
//
// Optional feature macro: SHREG_ROTATE_EN
//   When defined, the rot_i port exists. rot_i=1 feeds the bit that leaves
//   the register back in as the serial input, so the register rotates
//   instead of shifting. This applies to single shifts and to bursts.
//   When undefined, the serial inputs are always sin_r_i / sin_l_i.
//
// Parameters
//   WIDTH      register width in bits (>= 2)
//   RESET_VAL  value of q on reset and on clear
//   CNT_W      width of len_i and the burst counter (derived, do not override)
//
// Ports
//   clk_i     rising-edge clock
//   rst_i     asynchronous active-high reset
//   clr_i     synchronous clear; highest priority after reset
//   mode_i    00 hold, 01 shift right, 10 shift left, 11 parallel load
//   d_i       parallel load data
//   sin_r_i   serial input for right shift; enters q[WIDTH-1]
//   sin_l_i   serial input for left shift; enters q[0]
//   start_i   begin a burst in the direction given by mode_i (01/10)
//   len_i     number of burst shifts (saturates at WIDTH)
//   rot_i     rotate select (SHREG_ROTATE_EN only)
//   q_o       register contents
//   q_n_o     inverted register contents
//   sout_r_o  q[0], the bit leaving on a right shift
//   sout_l_o  q[WIDTH-1], the bit leaving on a left shift
//   busy_o    high while a burst is shifting
//   done_o    one-cycle pulse after a burst completes
// ---------------------------------------------------------------------------
module shift_reg_universal #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             sin_r_i,
    input  logic             sin_l_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
`ifdef SHREG_ROTATE_EN
    input  logic             rot_i,
`endif
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] q_n_o,
    output logic             sout_r_o,
    output logic             sout_l_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [1:0]       MODE_HOLD  = 2'b00;
    localparam logic [1:0]       MODE_RIGHT = 2'b01;
    localparam logic [1:0]       MODE_LEFT  = 2'b10;
    localparam logic [1:0]       MODE_LOAD  = 2'b11;
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dirLeft_q, dirLeft_d;
    logic             done_q, done_d;

    logic             rightIn;
    logic             leftIn;
    logic [WIDTH-1:0] shiftedRight;
    logic [WIDTH-1:0] shiftedLeft;
    logic [CNT_W-1:0] burstLen;

    // Serial input selection: with rotation enabled the departing bit
    // re-enters at the opposite end.
    always_comb begin
`ifdef SHREG_ROTATE_EN
        rightIn = rot_i ? q_q[0]       : sin_r_i;
        leftIn  = rot_i ? q_q[WIDTH-1] : sin_l_i;
`else
        rightIn = sin_r_i;
        leftIn  = sin_l_i;
`endif
    end

    assign shiftedRight = {rightIn, q_q[WIDTH-1:1]};
    assign shiftedLeft  = {q_q[WIDTH-2:0], leftIn};

    // Requests longer than the register saturate so the counter never wraps.
    assign burstLen = (len_i > MAX_CNT) ? MAX_CNT : len_i;

    // Next-state logic. Priority: clear, then an active burst, then a burst
    // start request, then the per-cycle mode.
    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        dirLeft_d = dirLeft_q;
        done_d    = 1'b0;

        if (clr_i) begin
            // Aborting a burst deliberately produces no done pulse.
            state_d = IDLE;
            q_d     = RESET_VAL;
            cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            q_d   = dirLeft_q ? shiftedLeft : shiftedRight;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (start_i && (mode_i == MODE_RIGHT || mode_i == MODE_LEFT)) begin
            // The start edge only latches the request; shifting begins on
            // the following edge. A zero-length burst completes at once.
            dirLeft_d = (mode_i == MODE_LEFT);
            cnt_d     = burstLen;
            if (burstLen != '0) begin
                state_d = SHIFT;
            end else begin
                done_d = 1'b1;
            end
        end else begin
            case (mode_i)
                MODE_HOLD:  q_d = q_q;
                MODE_RIGHT: q_d = shiftedRight;
                MODE_LEFT:  q_d = shiftedLeft;
                MODE_LOAD:  q_d = d_i;
                default:    q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            q_q       <= RESET_VAL;
            cnt_q     <= '0;
            dirLeft_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            dirLeft_q <= dirLeft_d;
            done_q    <= done_d;
        end
    end

    assign q_o      = q_q;
    assign q_n_o    = ~q_q;
    assign sout_r_o = q_q[0];
    assign sout_l_o = q_q[WIDTH-1];
    assign busy_o   = (state_q == SHIFT);
    assign done_o   = done_q;

endmodule
